// File: rtl/bus_pkg.sv
// Shared definitions for the peripheral-bus Wishbone arbiter: FSM encoding,
// master indices and default bus geometry.
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } arb_state_e;

  localparam int M0_IDX = 0;
  localparam int M1_IDX = 1;

  localparam int WB_ADDR_W  = 32;
  localparam int WB_DATA_W  = 32;
  localparam int WB_SEL_W   = 4;
  localparam int WB_TIMEOUT = 1024;

endpackage

// File: rtl/wb_timeout_watchdog.sv
// Stall watchdog: counts strobe cycles without a termination and flags the
// TIMEOUT-th one so the arbiter can abort the cycle.
module wb_timeout_watchdog
  import bus_pkg::*;
#(
  parameter int TIMEOUT = WB_TIMEOUT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic run_i,
  output logic expire_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (run_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Clear already covers any termination, so a late ack beats the abort.
  assign expire_o = run_i && !clear_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/wb_bus_arbiter.sv
// Two-master, one-slave Wishbone arbiter with round-robin grants, bus lock
// and a watchdog that aborts stalled strobes with an error.
module wb_bus_arbiter
  import bus_pkg::*;
#(
  parameter int ADDR_W  = WB_ADDR_W,
  parameter int DATA_W  = WB_DATA_W,
  parameter int TIMEOUT = WB_TIMEOUT
) (
  input  logic              clk_i,
  input  logic              ext_rst_i,
  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_dat_i,
  input  logic [3:0]        m0_sel_i,
  input  logic              m0_lock_i,
  output logic [DATA_W-1:0] m0_dat_o,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  output logic              m0_rty_o,
  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_dat_i,
  input  logic [3:0]        m1_sel_i,
  input  logic              m1_lock_i,
  output logic [DATA_W-1:0] m1_dat_o,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic              m1_rty_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [ADDR_W-1:0] s_addr_o,
  output logic [DATA_W-1:0] s_dat_o,
  output logic [3:0]        s_sel_o,
  output logic              s_lock_o,
  input  logic [DATA_W-1:0] s_dat_i,
  input  logic              s_ack_i,
  input  logic              s_err_i,
  input  logic              s_rty_i,
  output logic [1:0]        grant_o,
  output logic              timeout_o
);

  arb_state_e state_q, state_d;
  logic       last_q, last_d;
  logic       req0, req1;
  logic       stb_raw, any_term, wd_clear, expire;

  assign req0 = m0_cyc_i | m0_stb_i;
  assign req1 = m1_cyc_i | m1_stb_i;

  // Watchdog looks at the unforced strobe so the abort cannot feed back on itself.
  assign stb_raw  = ((state_q == ST_GNT0) && m0_stb_i) || ((state_q == ST_GNT1) && m1_stb_i);
  assign any_term = s_ack_i | s_err_i | s_rty_i;
  assign wd_clear = (state_q == ST_IDLE) || !stb_raw || any_term;

  wb_timeout_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk_i    (clk_i),
    .rst_ni   (ext_rst_i),
    .clear_i  (wd_clear),
    .run_i    (stb_raw),
    .expire_o (expire)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (req0 && (!req1 || (last_q == 1'(M1_IDX)))) begin
          state_d = ST_GNT0;
          last_d  = 1'(M0_IDX);
        end else if (req1) begin
          state_d = ST_GNT1;
          last_d  = 1'(M1_IDX);
        end
      end
      ST_GNT0: begin
        if (expire || (!req0 && !m0_lock_i)) state_d = ST_IDLE;
      end
      ST_GNT1: begin
        if (expire || (!req1 && !m1_lock_i)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!ext_rst_i) begin
      state_q <= ST_IDLE;
      last_q  <= 1'(M1_IDX);
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_addr_o = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    s_lock_o = 1'b0;
    m0_dat_o = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m0_rty_o = 1'b0;
    m1_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    m1_rty_o = 1'b0;
    case (state_q)
      ST_GNT0: begin
        s_cyc_o  = m0_cyc_i & ~expire;
        s_stb_o  = m0_stb_i & ~expire;
        s_we_o   = m0_we_i;
        s_addr_o = m0_addr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        s_lock_o = m0_lock_i;
        m0_dat_o = s_dat_i;
        m0_ack_o = s_ack_i;
        m0_err_o = s_err_i | expire;
        m0_rty_o = s_rty_i;
      end
      ST_GNT1: begin
        s_cyc_o  = m1_cyc_i & ~expire;
        s_stb_o  = m1_stb_i & ~expire;
        s_we_o   = m1_we_i;
        s_addr_o = m1_addr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        s_lock_o = m1_lock_i;
        m1_dat_o = s_dat_i;
        m1_ack_o = s_ack_i;
        m1_err_o = s_err_i | expire;
        m1_rty_o = s_rty_i;
      end
      default: ;
    endcase
  end

  assign grant_o   = {state_q == ST_GNT1, state_q == ST_GNT0};
  assign timeout_o = expire;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Self-checking bench for wb_bus_arbiter: table-driven arbitration vectors
// plus directed lock, watchdog and mid-cycle reset sequences.
module tb_wb_bus_arbiter;

  logic        clk = 1'b0;
  logic        ext_rst = 1'b0;
  logic        m0_cyc = 0, m0_stb = 0, m0_we = 0, m0_lock = 0;
  logic [31:0] m0_addr = 32'h8, m0_dat = 32'h0;
  logic [3:0]  m0_sel = 4'hF;
  logic        m1_cyc = 0, m1_stb = 0, m1_we = 0, m1_lock = 0;
  logic [31:0] m1_addr = 32'h7, m1_dat = 32'h0;
  logic [3:0]  m1_sel = 4'hF;
  logic [31:0] s_dat = 32'h0;
  logic        s_ack = 0, s_err = 0, s_rty = 0;

  logic [31:0] m0_dat_o, m1_dat_o, s_addr_o, s_dat_o;
  logic        m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o;
  logic        s_cyc_o, s_stb_o, s_we_o, s_lock_o, timeout_o;
  logic [3:0]  s_sel_o;
  logic [1:0]  grant_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wb_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .clk_i(clk), .ext_rst_i(ext_rst),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_addr_i(m0_addr),
    .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_lock_i(m0_lock),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_addr_i(m1_addr),
    .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_lock_i(m1_lock),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o),
    .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_lock_o(s_lock_o),
    .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  typedef struct {
    logic        rst_n;
    logic        req0;
    logic        req1;
    logic        ack;
    logic [31:0] sdat;
    logic [1:0]  e_grant;
    logic        e_stb;
    logic        e_ack0;
    logic        e_ack1;
    logic [31:0] e_dat0;
    logic [31:0] e_dat1;
    logic [31:0] e_addr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst_n, logic r0, logic r1, logic ack, logic [31:0] sdat,
                              logic [1:0] eg, logic estb, logic ea0, logic ea1,
                              logic [31:0] ed0, logic [31:0] ed1, logic [31:0] eaddr);
    vec_t v;
    v.rst_n = rst_n; v.req0 = r0; v.req1 = r1; v.ack = ack; v.sdat = sdat;
    v.e_grant = eg; v.e_stb = estb; v.e_ack0 = ea0; v.e_ack1 = ea1;
    v.e_dat0 = ed0; v.e_dat1 = ed1; v.e_addr = eaddr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m0(input logic req);
    m0_cyc = req; m0_stb = req;
  endtask

  task automatic set_m1(input logic req);
    m1_cyc = req; m1_stb = req;
  endtask

  task automatic reset_pulse();
    ext_rst = 1'b0;
    tick();
    ext_rst = 1'b1;
  endtask

  initial begin
    logic [1:0] g;
    logic [31:0] d;

    // Reset and idle
    vecs.push_back(mk(0, 0, 0, 0, 32'h0, 2'b00, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 32'h5A, 2'b00, 0, 0, 0, 0, 0, 0));
    // m0 single read of 0x8, slave stalls then acks with 0x60
    vecs.push_back(mk(1, 1, 0, 0, 32'hDEAD, 2'b01, 1, 0, 0, 32'hDEAD, 0, 32'h8));
    vecs.push_back(mk(1, 1, 0, 0, 32'hDEAD, 2'b01, 1, 0, 0, 32'hDEAD, 0, 32'h8));
    vecs.push_back(mk(1, 1, 0, 0, 32'hDEAD, 2'b01, 1, 0, 0, 32'hDEAD, 0, 32'h8));
    vecs.push_back(mk(1, 1, 0, 1, 32'h60, 2'b01, 1, 1, 0, 32'h60, 0, 32'h8));
    vecs.push_back(mk(1, 0, 0, 0, 32'h60, 2'b00, 0, 0, 0, 0, 0, 0));
    // Fresh reset, then 8 ties alternating from m0
    vecs.push_back(mk(0, 0, 0, 0, 32'h0, 2'b00, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 8; i++) begin
      g = (i % 2 == 0) ? 2'b01 : 2'b10;
      d = 32'h100 + 32'(i);
      vecs.push_back(mk(1, 1, 1, 1, d, g, 1, g[0], g[1],
                        g[0] ? d : 32'h0, g[1] ? d : 32'h0, g[0] ? 32'h8 : 32'h7));
      vecs.push_back(mk(1, 0, 0, 0, d, 2'b00, 0, 0, 0, 0, 0, 0));
    end

    foreach (vecs[i]) begin
      ext_rst = vecs[i].rst_n;
      set_m0(vecs[i].req0);
      set_m1(vecs[i].req1);
      s_ack = vecs[i].ack;
      s_dat = vecs[i].sdat;
      tick();
      $display("vec %0d: grant=%b stb=%b ack0=%b ack1=%b dat0=%h", i, grant_o, s_stb_o,
               m0_ack_o, m1_ack_o, m0_dat_o);
      chk($sformatf("v%0d grant", i), 32'(grant_o), 32'(vecs[i].e_grant));
      chk($sformatf("v%0d s_stb", i), 32'(s_stb_o), 32'(vecs[i].e_stb));
      chk($sformatf("v%0d s_addr", i), s_addr_o, vecs[i].e_addr);
      chk($sformatf("v%0d m0_ack", i), 32'(m0_ack_o), 32'(vecs[i].e_ack0));
      chk($sformatf("v%0d m1_ack", i), 32'(m1_ack_o), 32'(vecs[i].e_ack1));
      chk($sformatf("v%0d m0_dat", i), m0_dat_o, vecs[i].e_dat0);
      chk($sformatf("v%0d m1_dat", i), m1_dat_o, vecs[i].e_dat1);
    end
    s_ack = 0;
    set_m0(0); set_m1(0);

    // Lock: m1 holds the bus across two writes while m0 waits
    reset_pulse();
    m1_we = 1; m1_lock = 1; m1_addr = 32'h7; m1_dat = 32'h31; set_m1(1);
    tick();
    $display("lock: m1 write 0x7 grant=%b", grant_o);
    chk("lock grant m1", 32'(grant_o), 32'h2);
    chk("lock s_dat w1", s_dat_o, 32'h31);
    chk("lock s_we", 32'(s_we_o), 32'h1);
    chk("lock s_lock", 32'(s_lock_o), 32'h1);
    set_m0(1); s_ack = 1;
    tick();
    chk("lock m1_ack w1", 32'(m1_ack_o), 32'h1);
    chk("lock m0_ack w1", 32'(m0_ack_o), 32'h0);
    s_ack = 0; set_m1(0);
    for (int i = 0; i < 2; i++) begin
      tick();
      $display("lock: gap cycle %0d grant=%b", i, grant_o);
      chk("lock hold grant", 32'(grant_o), 32'h2);
      chk("lock gap s_cyc", 32'(s_cyc_o), 32'h0);
    end
    m1_addr = 32'h3; m1_dat = 32'h80; set_m1(1);
    tick();
    $display("lock: m1 write 0x3 grant=%b", grant_o);
    chk("lock grant w2", 32'(grant_o), 32'h2);
    chk("lock s_addr w2", s_addr_o, 32'h3);
    chk("lock s_dat w2", s_dat_o, 32'h80);
    s_ack = 1;
    tick();
    chk("lock m1_ack w2", 32'(m1_ack_o), 32'h1);
    s_ack = 0; set_m1(0); m1_lock = 0; m1_we = 0;
    tick();
    chk("unlock idle", 32'(grant_o), 32'h0);
    tick();
    $display("lock: released, grant=%b", grant_o);
    chk("unlock m0 grant", 32'(grant_o), 32'h1);
    chk("unlock s_addr", s_addr_o, 32'h8);
    set_m0(0);
    tick();

    // Watchdog abort after 16 stalled strobe cycles
    reset_pulse();
    set_m0(1);
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk($sformatf("wd c%0d timeout", i), 32'(timeout_o), 32'h0);
      chk($sformatf("wd c%0d err", i), 32'(m0_err_o), 32'h0);
      chk($sformatf("wd c%0d stb", i), 32'(s_stb_o), 32'h1);
    end
    tick();
    $display("timeout: cycle 16 err=%b timeout=%b stb=%b", m0_err_o, timeout_o, s_stb_o);
    chk("wd16 err", 32'(m0_err_o), 32'h1);
    chk("wd16 timeout", 32'(timeout_o), 32'h1);
    chk("wd16 s_stb", 32'(s_stb_o), 32'h0);
    chk("wd16 s_cyc", 32'(s_cyc_o), 32'h0);
    chk("wd16 m1_err", 32'(m1_err_o), 32'h0);
    tick();
    chk("wd17 idle", 32'(grant_o), 32'h0);
    chk("wd17 timeout", 32'(timeout_o), 32'h0);
    tick();
    chk("wd18 regrant", 32'(grant_o), 32'h1);
    set_m0(0);
    tick();

    // Ack arriving in the 16th stalled cycle wins over the abort
    reset_pulse();
    set_m0(1);
    for (int i = 1; i <= 16; i++) tick();
    s_ack = 1; s_dat = 32'hA5;
    #1;
    $display("late ack: ack=%b err=%b timeout=%b", m0_ack_o, m0_err_o, timeout_o);
    chk("late ack", 32'(m0_ack_o), 32'h1);
    chk("late err", 32'(m0_err_o), 32'h0);
    chk("late timeout", 32'(timeout_o), 32'h0);
    chk("late s_stb", 32'(s_stb_o), 32'h1);
    chk("late dat", m0_dat_o, 32'hA5);
    s_ack = 0; set_m0(0);
    tick();

    // Reset in the middle of an m1 write
    reset_pulse();
    m1_we = 1; m1_addr = 32'h7; m1_dat = 32'h31; set_m1(1);
    tick();
    chk("rst pre grant", 32'(grant_o), 32'h2);
    ext_rst = 0; s_ack = 1;
    tick();
    $display("midreset: grant=%b s_cyc=%b", grant_o, s_cyc_o);
    chk("rst grant", 32'(grant_o), 32'h0);
    chk("rst s_cyc", 32'(s_cyc_o), 32'h0);
    chk("rst s_stb", 32'(s_stb_o), 32'h0);
    chk("rst s_addr", s_addr_o, 32'h0);
    chk("rst s_dat", s_dat_o, 32'h0);
    chk("rst m1_ack", 32'(m1_ack_o), 32'h0);
    s_ack = 0; set_m0(1);
    tick();
    chk("rst hold", 32'(grant_o), 32'h0);
    ext_rst = 1;
    tick();
    $display("midreset: tie after release grant=%b", grant_o);
    chk("rst tie m0", 32'(grant_o), 32'h1);
    set_m0(0); set_m1(0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
